// File: rtl/dso_pkg.sv
// Shared definitions for the host command path: command geometry, opcodes and
// the serial receiver state encoding.
package dso_pkg;

  localparam int CMD_W        = 24;
  localparam int CMD_BYTES    = 3;
  localparam int BAUD_DIV_DEF = 347;
  localparam int TO_CLKS_DEF  = 6940;

  // Opcodes carried in cmd[23:16], decoded by dig_core.
  typedef enum logic [7:0] {
    OP_NOP     = 8'h00,
    OP_WR_REG  = 8'h01,
    OP_RD_REG  = 8'h02,
    OP_TRIG    = 8'h10,
    OP_ARM     = 8'h11,
    OP_DUMP    = 8'h20
  } opcode_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_cmd_rcv_if.sv
// Command handoff between the UART command receiver and dig_core.
interface uart_cmd_rcv_if;
  import dso_pkg::*;

  // cmd_rdy rises with a new cmd and stays high until the consumer pulses
  // clr_cmd_rdy; a set in the same clock as clr_cmd_rdy wins.
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             frm_err;

  modport master (output cmd, output cmd_rdy, output frm_err, input clr_cmd_rdy);
  modport slave  (input cmd, input cmd_rdy, input frm_err, output clr_cmd_rdy);

endinterface

// File: rtl/uart_cmd_rcv_rx_byte.sv
// 8N1 byte receiver: two-flop RX synchroniser, bit-timing FSM and LSB-first
// shift register. rx_rdy/rx_ferr are single-cycle, aligned with the stop sample.
module uart_rx_byte
  import dso_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  output logic [7:0] rx_data,
  output logic      rx_rdy,
  output logic      rx_ferr,
  output rx_state_e state
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);

  logic          rx_s1, rx_s2, rx_prev;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          cnt_clr;
  logic          shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    rx_rdy   = 1'b0;
    rx_ferr  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_prev && !rx_s2) state_d = RX_START;
      end
      RX_START: begin
        if (baud_cnt == HALF_END) begin
          cnt_clr = 1'b1;
          state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt == BIT_END) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_cnt == BIT_END) begin
          cnt_clr = 1'b1;
          state_d = RX_IDLE;
          rx_rdy  = rx_s2;
          rx_ferr = !rx_s2;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Restarting the baud counter at each sample keeps every bit centred on
  // its own half-bit offset instead of accumulating rounding error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
      if (state_q == RX_START && state_d == RX_DATA) bit_cnt <= '0;
      else if (shift_en)                             bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_q <= {rx_s2, shift_q[7:1]};
    end
  end

  assign rx_data = shift_q;
  assign state   = state_q;

endmodule

// File: rtl/uart_cmd_rcv.sv
// Host command front end: assembles three received bytes into one 24-bit
// command, holds it for dig_core and drops stale partial frames on timeout.
module uart_cmd_rcv
  import dso_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int TO_CLKS  = TO_CLKS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           RX,
  uart_cmd_rcv_if.master host,
  output rx_state_e      dbg_rx_state,
  output logic [1:0]     dbg_byte_cnt
);

  localparam int TW = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0] TO_END = TW'(TO_CLKS);

  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             rx_ferr;
  rx_state_e        rx_state;

  logic [1:0]       byte_cnt;
  logic [7:0]       stg_hi, stg_mid;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_rdy_q;
  logic             frm_err_q;
  logic [TW-1:0]    to_cnt;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_ferr (rx_ferr),
    .state   (rx_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      stg_hi   <= '0;
      stg_mid  <= '0;
      cmd_q    <= '0;
      to_cnt   <= '0;
    end else if (rx_rdy) begin
      to_cnt <= '0;
      case (byte_cnt)
        2'd0: begin
          stg_hi   <= rx_data;
          byte_cnt <= 2'd1;
        end
        2'd1: begin
          stg_mid  <= rx_data;
          byte_cnt <= 2'd2;
        end
        default: begin
          cmd_q    <= {stg_hi, stg_mid, rx_data};
          byte_cnt <= 2'd0;
        end
      endcase
    end else if (rx_ferr) begin
      byte_cnt <= 2'd0;
      to_cnt   <= '0;
    end else if (byte_cnt != 2'd0 && rx_state == RX_IDLE) begin
      // Partial frame left idle too long: realign on the next byte.
      if (to_cnt == TO_END) begin
        byte_cnt <= 2'd0;
        to_cnt   <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= rx_ferr;
      if (rx_rdy && byte_cnt == 2'd2) cmd_rdy_q <= 1'b1;
      else if (host.clr_cmd_rdy)      cmd_rdy_q <= 1'b0;
    end
  end

  assign host.cmd     = cmd_q;
  assign host.cmd_rdy = cmd_rdy_q;
  assign host.frm_err = frm_err_q;
  assign dbg_rx_state = rx_state;
  assign dbg_byte_cnt = byte_cnt;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Bench for uart_cmd_rcv: serial byte driver, frame-level reference model and
// a per-cycle compare process; timing parameters scaled down for run time.
module tb_uart_cmd_rcv;
  import dso_pkg::*;

  localparam int B    = 40;
  localparam int T    = 800;
  localparam int W_LO = B / 2 - 4;
  localparam int W_HI = B / 2 + 10;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      rx;
  rx_state_e dbg_rx_state;
  logic [1:0] dbg_byte_cnt;

  uart_cmd_rcv_if bus ();

  uart_cmd_rcv #(.BAUD_DIV(B), .TO_CLKS(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX           (rx),
    .host         (bus.master),
    .dbg_rx_state (dbg_rx_state),
    .dbg_byte_cnt (dbg_byte_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs and the bytes of the frame in progress.
  logic [23:0] exp_cmd;
  logic        exp_rdy;
  logic [7:0]  part_q[$];
  int          since_byte;
  bit          win;
  int          win_rdy_hi, win_ferr_hi;
  int          checks, errors;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Outside stop-bit windows every output must equal the model exactly.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      since_byte++;
      if (win) begin
        if (bus.cmd_rdy) win_rdy_hi++;
        if (bus.frm_err) win_ferr_hi++;
      end else begin
        check("cycle_cmd", 32'(bus.cmd), 32'(exp_cmd));
        check("cycle_cmd_rdy", 32'(bus.cmd_rdy), 32'(exp_rdy));
        check("cycle_frm_err", 32'(bus.frm_err), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] data, input bit stop_ok, input bit hold_clr);
    bit set_ev;
    bit prev_rdy;
    if (part_q.size() != 0 && since_byte > T) part_q.delete();
    check("byte_cnt", 32'(dbg_byte_cnt), 32'(part_q.size()));
    @(negedge clk);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (B) @(negedge clk);
    end
    rx = stop_ok;
    repeat (W_LO) @(negedge clk);
    #1;
    win_rdy_hi  = 0;
    win_ferr_hi = 0;
    win = 1'b1;
    if (hold_clr) bus.clr_cmd_rdy = 1'b1;
    repeat (W_HI - W_LO) @(negedge clk);
    #1;
    prev_rdy = exp_rdy;
    set_ev = 1'b0;
    if (stop_ok) begin
      since_byte = 0;
      if (part_q.size() == 2) begin
        exp_cmd = {part_q[0], part_q[1], data};
        exp_rdy = hold_clr ? 1'b0 : 1'b1;
        set_ev  = 1'b1;
        part_q.delete();
      end else begin
        part_q.push_back(data);
      end
    end else begin
      part_q.delete();
    end
    if (hold_clr) begin
      bus.clr_cmd_rdy = 1'b0;
      exp_rdy = 1'b0;
      check("set_beats_clr_hi_cycles", 32'(win_rdy_hi), 32'd1);
    end else if (!set_ev && !prev_rdy) begin
      check("no_spurious_rdy", 32'(win_rdy_hi), 32'd0);
    end
    check("frm_err_pulses", 32'(win_ferr_hi), stop_ok ? 32'd0 : 32'd1);
    win = 1'b0;
    repeat (B - W_HI) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (2 * B) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    #1 bus.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    win = 1'b0;
    since_byte = 0;
    exp_cmd = '0;
    exp_rdy = 1'b0;
    rst_n = 1'b0;
    rx = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_cmd", 32'(bus.cmd), 32'd0);
    check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("rst_frm_err", 32'(bus.frm_err), 32'd0);
    check("rst_byte_cnt", 32'(dbg_byte_cnt), 32'd0);
    check("rst_state", 32'(dbg_rx_state), 32'(RX_IDLE));
    #1 rst_n = 1'b1;
    idle(10);

    // Back-to-back frame.
    send_byte(8'h01, 1, 0);
    send_byte(8'h23, 1, 0);
    send_byte(8'h45, 1, 0);
    check("t1_cmd", 32'(bus.cmd), 32'h012345);
    check("t1_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);

    // Consumer clears cmd_rdy; cmd is kept.
    idle(20);
    pulse_clr();
    idle(3);
    check("t2_cmd_rdy_cleared", 32'(bus.cmd_rdy), 32'd0);
    check("t2_cmd_kept", 32'(bus.cmd), 32'h012345);

    // Short low glitch mid-frame must not count as a byte.
    send_byte(8'h5A, 1, 0);
    @(negedge clk);
    rx = 1'b0;
    idle(B / 2 - 8);
    rx = 1'b1;
    idle(2 * B);
    check("t3_byte_cnt_kept", 32'(dbg_byte_cnt), 32'd1);
    send_byte(8'h67, 1, 0);
    // Clear held across the set clock of this frame.
    send_byte(8'h89, 1, 1);
    check("t3_cmd", 32'(bus.cmd), 32'h5A6789);

    // Framing error drops the partial frame.
    send_byte(8'h11, 1, 0);
    send_byte(8'h99, 0, 0);
    check("t4_byte_cnt_after_ferr", 32'(dbg_byte_cnt), 32'd0);
    send_byte(8'hAA, 1, 0);
    send_byte(8'hBB, 1, 0);
    send_byte(8'hCC, 1, 0);
    check("t4_cmd", 32'(bus.cmd), 32'hAABBCC);

    // Partial frame timeout.
    send_byte(8'h77, 1, 0);
    send_byte(8'h88, 1, 0);
    idle(T + 200);
    send_byte(8'h10, 1, 0);
    send_byte(8'h20, 1, 0);
    send_byte(8'h30, 1, 0);
    check("t5_cmd", 32'(bus.cmd), 32'h102030);

    // Randomized traffic: gaps far from the timeout threshold either way.
    for (int n = 0; n < 50; n++) begin
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0), 0);
      if (exp_rdy && $urandom_range(0, 2) == 0) pulse_clr();
      if ($urandom_range(0, 5) == 0) idle($urandom_range(T + 300, T + 500));
      else                           idle($urandom_range(0, 100));
    end

    // Asynchronous reset in the middle of a bit of byte 2.
    send_byte(8'h55, 1, 0);
    @(negedge clk);
    rx = 1'b0;
    repeat (B + B / 2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_cmd", 32'(bus.cmd), 32'd0);
    check("t6_async_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("t6_async_byte_cnt", 32'(dbg_byte_cnt), 32'd0);
    exp_cmd = '0;
    exp_rdy = 1'b0;
    part_q.delete();
    rx = 1'b1;
    idle(5);
    #1 rst_n = 1'b1;
    idle(20 * B);
    send_byte(8'hDE, 1, 0);
    send_byte(8'hAD, 1, 0);
    send_byte(8'h01, 1, 0);
    check("t6_cmd", 32'(bus.cmd), 32'hDEAD01);
    check("t6_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
